// File: rtl/imem_loader_pkg.sv
// ============================================================================
//  Module  : imem_pkg
//  Brief   : Shared loader FSM encoding and instruction-memory sizing constants.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package imem_pkg;

    localparam int unsigned C_INSTR_WIDTH = 32;
    localparam int unsigned C_MAX_WORDS   = 256;
    localparam int unsigned C_CNT_WIDTH   = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_LO = 3'd1,
        S_HDR_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    function automatic logic is_busy(input state_t s);
        return !(s inside {S_IDLE, S_DONE, S_ERROR});
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
//  Module  : imem_loader_if
//  Brief   : Byte-stream handshake plus instruction-memory write port.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if #(
    parameter int unsigned WIDTH = imem_pkg::C_INSTR_WIDTH
) ();
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             wr_en;
    logic [WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;

    // master: byte source and memory side; slave: the loader
    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader_packer.sv
// ============================================================================
//  Module  : imem_word_packer
//  Brief   : Shifts bytes into a little-endian 32-bit word and flags the 4th.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module imem_word_packer (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        clear,
    input  wire logic        byte_en,
    input  wire logic [7:0]  byte_in,
    output logic      [31:0] word,
    output logic             word_full
);
    logic [1:0]  idx_q, idx_d;
    logic [31:0] buf_q, buf_d;

    // Right shift: after four bytes the first one lands in bits 7:0
    always_comb begin
        idx_d = idx_q;
        buf_d = buf_q;
        if (clear) begin
            idx_d = '0;
            buf_d = '0;
        end else if (byte_en) begin
            idx_d = idx_q + 2'd1;
            buf_d = {byte_in, buf_q[31:8]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            buf_q <= '0;
        end else begin
            idx_q <= idx_d;
            buf_q <= buf_d;
        end
    end

    assign word      = buf_q;
    assign word_full = byte_en && (idx_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module  : imem_loader
//  Brief   : Fills instruction memory from a length-prefixed byte stream.
//            Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned WIDTH     = C_INSTR_WIDTH,
    parameter int unsigned MAX_WORDS = C_MAX_WORDS,
    parameter int unsigned CNT_WIDTH = C_CNT_WIDTH
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 start,
    imem_loader_if.slave              bus,
    output logic                      cpu_stall,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic      [CNT_WIDTH-1:0] words_written
);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 stall_q, stall_d;

    logic                 w_in_ready;
    logic                 w_xfer;
    logic                 w_start_ok;
    logic [CNT_WIDTH-1:0] w_hdr_len;
    logic [31:0]          w_word;
    logic                 w_word_full;

    assign w_in_ready = state_q inside {S_HDR_LO, S_HDR_HI, S_DATA, S_CHECK};
    assign w_xfer     = bus.in_valid && w_in_ready;
    assign w_start_ok = start && !is_busy(state_q);
    assign w_hdr_len  = CNT_WIDTH'({bus.in_data, len_q[7:0]});

    imem_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_start_ok),
        .byte_en   (w_xfer && (state_q == S_DATA)),
        .byte_in   (bus.in_data),
        .word      (w_word),
        .word_full (w_word_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;

    always_comb begin
        xor_d = xor_q;
        if (w_start_ok) begin
            xor_d = '0;
        end else if (w_xfer && (state_q inside {S_HDR_LO, S_HDR_HI, S_DATA})) begin
            xor_d = xor_q ^ bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xor_q <= '0;
        else        xor_q <= xor_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_HDR_LO;
                    len_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_HDR_LO: begin
                if (w_xfer) begin
                    len_d   = CNT_WIDTH'(bus.in_data);
                    state_d = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (w_xfer) begin
                    len_d = w_hdr_len;
                    if (w_hdr_len == '0)                  state_d = S_DONE;
                    else if (32'(w_hdr_len) > MAX_WORDS)  state_d = S_ERROR;
                    else                                  state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_word_full) state_d = S_WRITE;
            end
            S_WRITE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (w_xfer) state_d = (bus.in_data == xor_q) ? S_DONE : S_ERROR;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        stall_d = is_busy(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.wr_en     = (state_q == S_WRITE);
    assign bus.wr_addr   = WIDTH'({cnt_q, 2'b00});
    assign bus.wr_data   = WIDTH'(w_word);
    assign cpu_stall     = stall_q;
    assign busy          = is_busy(state_q);
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_ERROR);
    assign words_written = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module  : tb_imem_loader
//  Brief   : Scoreboard bench for imem_loader; expected writes are queued by
//            the stimulus and popped by a write-port monitor.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imem_loader;
    import imem_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cpu_stall, busy, done, error;
    logic [15:0] words_written;

    imem_loader_if #(.WIDTH(32)) bus ();

    imem_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .bus           (bus),
        .cpu_stall     (cpu_stall),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  run_x;
    logic [7:0]  s[$];
    logic [31:0] d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Write-port monitor: every wr_en must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && bus.wr_en) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.wr_addr !== mon_e.addr || bus.wr_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                             bus.wr_addr, bus.wr_data, mon_e.addr, mon_e.data);
                end
            end
            check("ready_in_write", {63'd0, bus.in_ready}, 64'd0);
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic [31:0] v);
        exp_q.push_back('{addr: a, data: v});
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_x = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget = 200;
        int g      = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_timeout: in_ready 0 for 200 cycles, required 1");
        end
        @(negedge clk);
    endtask

    task automatic send_stream(input logic [7:0] q[$], input bit gaps, input int csum_mode);
        foreach (q[i]) begin
            send_byte(q[i], gaps);
            run_x = run_x ^ q[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (csum_mode == 1)      send_byte(run_x, gaps);
        else if (csum_mode == 2) send_byte(8'hFF, gaps);
`else
        if (csum_mode > 2) run_x = 8'h00;
`endif
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int b = 3000;
        while (busy && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (b == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: busy still 1, required 0", name);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        run_x        = 8'h00;
        repeat (2) @(negedge clk);

        check("reset_flags", {58'd0, cpu_stall, busy, done, error, bus.in_ready, bus.wr_en}, 64'd0);
        check("reset_addr_data", {bus.wr_addr, bus.wr_data}, 64'd0);
        check("reset_count", {48'd0, words_written}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic two-word load, valid held high
        push_exp(32'd0, 32'h05F00263);
        push_exp(32'd4, 32'h01DE8D33);
        do_start();
        check("basic_stall_after_start", {63'd0, cpu_stall}, 64'd1);
        send_stream('{8'h02, 8'h00, 8'h63, 8'h02, 8'hF0, 8'h05, 8'h33, 8'h8D, 8'hDE, 8'h01}, 1'b0, 1);
        wait_end("basic");
        check("basic_done_err_stall", {61'd0, done, error, cpu_stall}, 64'b100);
        check("basic_words", {48'd0, words_written}, 64'd2);
        check("basic_all_written", 64'(exp_q.size()), 64'd0);

        // Same stream with random gaps on in_valid
        push_exp(32'd0, 32'h05F00263);
        push_exp(32'd4, 32'h01DE8D33);
        do_start();
        send_stream('{8'h02, 8'h00, 8'h63, 8'h02, 8'hF0, 8'h05, 8'h33, 8'h8D, 8'hDE, 8'h01}, 1'b1, 1);
        wait_end("gaps");
        check("gaps_done", {63'd0, done}, 64'd1);
        check("gaps_words", {48'd0, words_written}, 64'd2);
        check("gaps_all_written", 64'(exp_q.size()), 64'd0);

        // LEN=0: done right after the high header byte
        do_start();
        send_stream('{8'h00, 8'h00}, 1'b0, 0);
        check("len0_done_busy", {62'd0, done, busy}, 64'b10);
        check("len0_words", {48'd0, words_written}, 64'd0);

        // LEN=MaxWords: 256 words, last one at address 1020
        s = '{8'h00, 8'h01};
        for (int i = 0; i < 256; i++) begin
            d = {8'(i), 8'(i + 1), 8'hA5, ~8'(i)};
            push_exp(32'(i * 4), d);
            s.push_back(d[7:0]);
            s.push_back(d[15:8]);
            s.push_back(d[23:16]);
            s.push_back(d[31:24]);
        end
        do_start();
        send_stream(s, 1'b0, 1);
        wait_end("max");
        check("max_done", {63'd0, done}, 64'd1);
        check("max_words", {48'd0, words_written}, 64'd256);
        check("max_all_written", 64'(exp_q.size()), 64'd0);

        // LEN=257: rejected at the header
        do_start();
        send_stream('{8'h01, 8'h01}, 1'b0, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        check("over_error_ready_busy", {61'd0, error, bus.in_ready, busy}, 64'b100);
        check("over_words", {48'd0, words_written}, 64'd0);
        bus.in_valid = 1'b0;

        // Reset after 6 data bytes: first word already written
        push_exp(32'd0, 32'h05F00263);
        do_start();
        send_stream('{8'h02, 8'h00, 8'h63, 8'h02, 8'hF0, 8'h05, 8'h33, 8'h8D}, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_flags", {58'd0, cpu_stall, busy, done, error, bus.in_ready, bus.wr_en}, 64'd0);
        check("rst_mid_count_addr", {words_written, bus.wr_addr[15:0], bus.wr_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_first_word", 64'(exp_q.size()), 64'd0);
        push_exp(32'd0, 32'h05F00263);
        push_exp(32'd4, 32'h01DE8D33);
        do_start();
        send_stream('{8'h02, 8'h00, 8'h63, 8'h02, 8'hF0, 8'h05, 8'h33, 8'h8D, 8'hDE, 8'h01}, 1'b0, 1);
        wait_end("post_rst");
        check("post_rst_done_words", {47'd0, done, words_written}, {47'd0, 1'b1, 16'd2});
        check("post_rst_all_written", 64'(exp_q.size()), 64'd0);

        // Start pulse mid-DATA is ignored
        push_exp(32'd0, 32'h05F00263);
        push_exp(32'd4, 32'h01DE8D33);
        do_start();
        send_stream('{8'h02, 8'h00, 8'h63, 8'h02}, 1'b0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_start_busy_err", {62'd0, busy, error}, 64'b10);
        send_stream('{8'hF0, 8'h05, 8'h33, 8'h8D, 8'hDE, 8'h01}, 1'b0, 1);
        wait_end("ign_start");
        check("ign_start_done_words", {47'd0, done, words_written}, {47'd0, 1'b1, 16'd2});
        check("ign_start_all_written", 64'(exp_q.size()), 64'd0);

        // Restart after done with a one-word image
        push_exp(32'd0, 32'h00000F82);
        do_start();
        check("restart_cleared", {47'd0, done, words_written}, 64'd0);
        send_stream('{8'h01, 8'h00, 8'h82, 8'h0F, 8'h00, 8'h00}, 1'b0, 1);
        wait_end("restart");
        check("restart_done_words", {47'd0, done, words_written}, {47'd0, 1'b1, 16'd1});
        check("restart_all_written", 64'(exp_q.size()), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Hand-computed checksum 01^00^82^0F^00^00 = 8C
        push_exp(32'd0, 32'h00000F82);
        do_start();
        send_stream('{8'h01, 8'h00, 8'h82, 8'h0F, 8'h00, 8'h00}, 1'b0, 0);
        send_byte(8'h8C, 1'b0);
        bus.in_valid = 1'b0;
        wait_end("csum_good");
        check("csum_good_done_err", {62'd0, done, error}, 64'b10);
        check("csum_good_written", 64'(exp_q.size()), 64'd0);

        push_exp(32'd0, 32'h00000F82);
        do_start();
        send_stream('{8'h01, 8'h00, 8'h82, 8'h0F, 8'h00, 8'h00}, 1'b0, 0);
        send_byte(8'hFF, 1'b0);
        bus.in_valid = 1'b0;
        wait_end("csum_bad");
        check("csum_bad_done_err", {62'd0, done, error}, 64'b01);
        check("csum_bad_still_written", 64'(exp_q.size()), 64'd0);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. The fetch path reads the memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Emits one write strobe per word at byte addresses 0, 4, 8, …, matching the PC stride used by fetch.
- Holds the core stalled while loading; sits between the host/debug byte source and the instruction memory write port.

Parameters:
- Width, 32, instruction word and write address width.
- MaxWords, 256, maximum words per image (byte address space 0..4*MaxWords-1).
- CntWidth, 16, width of the length header and word counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR; ignored while busy.
- in_valid  input  1  byte source has in_data available.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts in_data this cycle; a byte transfers when in_valid && in_ready.
- wr_en  output  1  one-cycle write strobe to instruction memory.
- wr_addr  output  Width  byte address of the word being written.
- wr_data  output  Width  assembled instruction word.
- cpu_stall  output  1  holds the core/PC while busy.
- busy  output  1  FSM is outside IDLE/DONE/ERROR.
- done  output  1  image fully written; level, held until next start.
- error  output  1  load aborted; level, held until next start.
- words_written  output  CntWidth  count of words written in the current/last load.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; internal byte index, word buffer and length cleared. Reset mid-load aborts immediately; memory contents already written are not undone.
- Stream format: 2-byte length header LEN (low byte first) = number of words, then LEN*4 data bytes, each word little-endian (first byte → bits 7:0).
- FSM states and transitions:
  - IDLE: start → HDR_LO.
  - HDR_LO: accept byte → HDR_HI.
  - HDR_HI: accept byte; if LEN==0 → DONE; if LEN>MaxWords → ERROR; else → DATA.
  - DATA: accept 4 bytes (byte index 0..3); the 4th accepted byte → WRITE.
  - WRITE: exactly 1 cycle; wr_en=1, wr_addr=words_written<<2, wr_data=assembled word; words_written+1; if the incremented count==LEN → DONE (or CHECK, see Optional Feature), else → DATA.
  - DONE and ERROR: start → HDR_LO, clearing done, error and words_written.
- Handshake:
  - in_ready=1 only in HDR_LO, HDR_HI, DATA (and CHECK); 0 in WRITE, so there is one bubble cycle per word.
  - in_valid may drop at any time; the FSM waits with no timeout.
  - in_data is ignored when no transfer occurs.
- Latency: wr_en asserts in the cycle after the 4th byte of a word transfers; done rises the cycle after the last WRITE.
- cpu_stall = busy, registered, asserted the cycle after start is accepted.
- start while busy is ignored. start coincident with a byte transfer in DONE does not consume that byte.
- Address arithmetic: wr_addr is zero-extended from words_written and never wraps, because LEN≤MaxWords is enforced at the header.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined: after the final WRITE the FSM enters CHECK and accepts one extra byte. If it equals the XOR of all header and data bytes → DONE, otherwise → ERROR. The running XOR is cleared on start.
- Undefined: there is no CHECK state and the last WRITE goes directly to DONE.

Decomposition:
- Shared package imem_pkg holds:
  - FSM state encoding: IDLE, HDR_LO, HDR_HI, DATA, WRITE, CHECK, DONE, ERROR.
  - Default MaxWords and instruction width constants, shared with the instruction memory.
- One natural sub-module: imem_word_packer, which holds the byte index, shifts bytes into a 32-bit buffer, and flags word_full. The FSM and address counter stay in imem_loader.

Test Plan:
- Basic load: start, stream 02 00 | 63 02 F0 05 | 33 8D DE 01, in_valid held high → two wr_en pulses: addr 0 data 32'h05F00263, then addr 4 data 32'h01DE8D33; done=1; words_written=2; cpu_stall high only between start and done.
- Backpressure/gaps: same stream with in_valid toggled randomly → identical writes; in_ready=0 during each WRITE cycle; no byte lost or duplicated.
- Boundaries:
  - LEN=0 → done the cycle after HDR_HI, with no wr_en.
  - LEN=MaxWords (256) → last write at addr 1020.
  - LEN=257 → error=1, no wr_en, in_ready=0.
- Reset mid-load: assert rst_n=0 after 6 data bytes → all outputs 0 asynchronously. A fresh start then loads correctly from addr 0.
- Restart and ignored start: pulse start during DATA → ignored. After done, pulse start and load 1 word 32'h00000F82 → written at addr 0; done/words_written cleared, then 1.
- Checksum (IMEM_LOADER_CHECKSUM_EN): 1-word image 01 00 82 0F 00 00 followed by the correct XOR byte 8C → done. Same image with FF → error, and the word has still been written at addr 0.
